// File: rtl/rr_mux4_arbiter.sv
// rtl/rr_mux4_arbiter.sv - round-robin grant sequencer driving the 4:1 mux selects
module rr_mux4_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_req,
  input  logic       i_ready,
  output logic [3:0] o_gnt,
  output logic       o_sel0,
  output logic       o_sel1,
  output logic       o_valid,
  output logic       o_last
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(MAX_BURST - 1);

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] g_q, g_d;
  logic [3:0] cnt_q, cnt_d;

  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic       valid_q, valid_d;

  logic       burst_end;
  logic [1:0] release_ptr;
  logic [2:0] idle_pick;
  logic [2:0] rearb_pick;

  // Returns {found, index} of the first set request scanning start, start+1, ... mod 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
    logic [2:0] r;
    logic [1:0] idx;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (req[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  assign burst_end   = (cnt_q == LAST_CNT) || !i_req[g_q];
  assign release_ptr = g_q + 2'd1;
  assign idle_pick   = rr_pick(i_req, ptr_q);
  assign rearb_pick  = rr_pick(i_req, release_ptr);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      g_q     <= 2'd0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      g_q     <= g_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    g_d     = g_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (idle_pick[2]) begin
          state_d = GRANT;
          g_d     = idle_pick[1:0];
          cnt_d   = 4'd0;
        end
      end
      GRANT: begin
        if (i_ready) begin
          if (burst_end) begin
            // Handover re-arbitrates against the advanced pointer in the same cycle.
            ptr_d = release_ptr;
            if (rearb_pick[2]) begin
              g_d   = rearb_pick[1:0];
              cnt_d = 4'd0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are precomputed from next state so they leave flops directly.
  always_comb begin
    valid_d = (state_d == GRANT);
    gnt_d   = valid_d ? (4'b0001 << g_d) : 4'b0000;
    sel_d   = g_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      gnt_q   <= 4'b0000;
      sel_q   <= 2'b00;
      valid_q <= 1'b0;
    end else begin
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
    end
  end

  assign o_gnt   = gnt_q;
  assign o_sel0  = sel_q[0];
  assign o_sel1  = sel_q[1];
  assign o_valid = valid_q;
  assign o_last  = (state_q == GRANT) && burst_end;

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// tb/tb_rr_mux4_arbiter.sv - randomized and directed checks of rr_mux4_arbiter against a behavioural model
module tb_rr_mux4_arbiter;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic [3:0] i_req;
  logic       i_ready;

  logic [3:0] gnt   [2];
  logic       sel0  [2];
  logic       sel1  [2];
  logic       valid [2];
  logic       last  [2];

  int checks = 0;
  int failures = 0;

  int mb     [2] = '{4, 1};
  int m_busy [2];
  int m_g    [2];
  int m_cnt  [2];
  int m_ptr  [2];

  always #5 i_clk = ~i_clk;

  rr_mux4_arbiter #(.MAX_BURST(4)) u_dut_b4 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_ready(i_ready),
    .o_gnt(gnt[0]), .o_sel0(sel0[0]), .o_sel1(sel1[0]), .o_valid(valid[0]), .o_last(last[0])
  );

  rr_mux4_arbiter #(.MAX_BURST(1)) u_dut_b1 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_ready(i_ready),
    .o_gnt(gnt[1]), .o_sel0(sel0[1]), .o_sel1(sel1[1]), .o_valid(valid[1]), .o_last(last[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int scan(input logic [3:0] req, input int start);
    for (int i = 0; i < 4; i++) begin
      if (req[(start + i) % 4]) return (start + i) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 0;
      m_g[k]    = 0;
      m_cnt[k]  = 0;
      m_ptr[k]  = 0;
    end
  endtask

  task automatic model_step();
    int w;
    if (!i_rst_n) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      if (m_busy[k] == 0) begin
        w = scan(i_req, m_ptr[k]);
        if (w >= 0) begin
          m_busy[k] = 1;
          m_g[k]    = w;
          m_cnt[k]  = 0;
        end
      end else if (i_ready) begin
        if (m_cnt[k] == mb[k] - 1 || !i_req[m_g[k]]) begin
          m_ptr[k] = (m_g[k] + 1) % 4;
          w = scan(i_req, m_ptr[k]);
          if (w >= 0) begin
            m_g[k]   = w;
            m_cnt[k] = 0;
          end else begin
            m_busy[k] = 0;
          end
        end else begin
          m_cnt[k] = m_cnt[k] + 1;
        end
      end
    end
  endtask

  task automatic check_all();
    int exp_gnt;
    int exp_last;
    for (int k = 0; k < 2; k++) begin
      exp_gnt  = (m_busy[k] != 0) ? (1 << m_g[k]) : 0;
      exp_last = (m_busy[k] != 0 && (m_cnt[k] == mb[k] - 1 || !i_req[m_g[k]])) ? 1 : 0;
      check($sformatf("model_gnt[%0d]", k), 32'(gnt[k]), 32'(exp_gnt));
      check($sformatf("model_sel[%0d]", k), 32'({sel1[k], sel0[k]}), 32'(m_g[k]));
      check($sformatf("model_valid[%0d]", k), 32'(valid[k]), 32'(m_busy[k]));
      check($sformatf("model_last[%0d]", k), 32'(last[k]), 32'(exp_last));
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    model_step();
    @(negedge i_clk);
    check_all();
  endtask

  task automatic drive(input logic [3:0] req, input logic rdy);
    i_req   = req;
    i_ready = rdy;
    #1;
    check_all();
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    i_req   = 4'b0000;
    i_ready = 1'b0;
    model_reset();
    cyc();
    cyc();
    i_rst_n = 1'b1;
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_req   = 4'b0000;
    i_ready = 1'b0;
    model_reset();
    @(negedge i_clk);
    check("reset_gnt", 32'(gnt[0]), 32'h0);
    check("reset_valid", 32'(valid[0]), 32'h0);
    do_reset();

    // Single requester, burst of 4 then zero-bubble re-grant to the same index.
    drive(4'b0100, 1'b1);
    cyc();
    check("single_gnt", 32'(gnt[0]), 32'h4);
    check("single_sel", 32'({sel1[0], sel0[0]}), 32'h2);
    check("single_last_b1", 32'(last[0]), 32'h0);
    cyc();
    cyc();
    cyc();
    check("single_last_b4", 32'(last[0]), 32'h1);
    cyc();
    check("regrant_gnt", 32'(gnt[0]), 32'h4);
    check("regrant_valid", 32'(valid[0]), 32'h1);
    check("regrant_last", 32'(last[0]), 32'h0);
    cyc();
    cyc();

    // Asynchronous reset between edges with g=2, cnt=2.
    #2;
    i_rst_n = 1'b0;
    #1;
    model_reset();
    check("midrst_gnt", 32'(gnt[0]), 32'h0);
    check("midrst_sel", 32'({sel1[0], sel0[0]}), 32'h0);
    check("midrst_valid", 32'(valid[0]), 32'h0);
    check("midrst_last", 32'(last[0]), 32'h0);
    check_all();
    i_req = 4'b0000;
    #1;
    i_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("post_rst_valid", 32'(valid[0]), 32'h0);
    end

    // Full rotation on the MAX_BURST=1 instance.
    do_reset();
    drive(4'b1111, 1'b1);
    for (int i = 0; i < 5; i++) begin
      logic [3:0] exp_rot;
      exp_rot = 4'b0001 << (i % 4);
      cyc();
      check("rotate_gnt", 32'(gnt[1]), 32'(exp_rot));
      check("rotate_sel", 32'({sel1[1], sel0[1]}), 32'(i % 4));
    end

    // Backpressure at cnt=1 while toggling i_req[0].
    do_reset();
    drive(4'b0001, 1'b1);
    cyc();
    cyc();
    for (int i = 0; i < 5; i++) begin
      drive({3'b000, i[0]}, 1'b0);
      cyc();
      check("stall_gnt", 32'(gnt[0]), 32'h1);
      check("stall_sel", 32'({sel1[0], sel0[0]}), 32'h0);
      check("stall_valid", 32'(valid[0]), 32'h1);
    end
    drive(4'b0001, 1'b1);
    check("stall_last_cnt1", 32'(last[0]), 32'h0);
    cyc();
    cyc();
    check("stall_last_cnt3", 32'(last[0]), 32'h1);

    // Early release after two beats.
    do_reset();
    drive(4'b0011, 1'b1);
    cyc();
    cyc();
    drive(4'b0010, 1'b1);
    check("early_last", 32'(last[0]), 32'h1);
    cyc();
    check("early_gnt", 32'(gnt[0]), 32'h2);
    check("early_sel", 32'({sel1[0], sel0[0]}), 32'h1);

    // Idle return from requester 3, then a fresh grant to 1.
    do_reset();
    drive(4'b1000, 1'b1);
    cyc();
    drive(4'b0000, 1'b1);
    check("idle_last", 32'(last[0]), 32'h1);
    cyc();
    check("idle_valid", 32'(valid[0]), 32'h0);
    check("idle_gnt", 32'(gnt[0]), 32'h0);
    check("idle_sel", 32'({sel1[0], sel0[0]}), 32'h3);
    drive(4'b0010, 1'b1);
    cyc();
    check("idle_regnt", 32'(gnt[0]), 32'h2);

    // Randomized traffic with occasional mid-cycle resets.
    for (int i = 0; i < 2000; i++) begin
      logic [3:0] r;
      r = ($urandom_range(0, 1) == 0) ? i_req : 4'($urandom_range(0, 15));
      drive(r, ($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 199) == 0) begin
        #1;
        i_rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #1;
        i_rst_n = 1'b1;
      end
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
